// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: active-low g..a patterns for hex 0-F
// and a decode function used by the digit decoder.
package sseg_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment (g..a) decoder.
module sseg_hex_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup; no state.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with tear-free
// double-buffered updates. Define SSEG_LEAD_ZERO_BLANK_EN to darken
// leading zero digits (digit 0 always shown, decimal points kept).
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV = 100000
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    output logic [7:0]              sseg_cathode,
    output logic [N_DIGITS-1:0]     sseg_anode,
    output logic                    frame_start
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    boundary;

    logic [4*N_DIGITS-1:0]   pend_val;
    logic [N_DIGITS-1:0]     pend_dp;
    logic [N_DIGITS-1:0]     pend_blank;
    logic                    pend_valid;
    logic [4*N_DIGITS-1:0]   disp_val;
    logic [N_DIGITS-1:0]     disp_dp;
    logic [N_DIGITS-1:0]     disp_blank;

    logic [N_DIGITS-1:0]     lzb_mask;
    logic [3:0]              nibble;
    logic                    dig_dp;
    logic                    dig_dark;
    logic [6:0]              seg;

    assign tick     = (cnt == CNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);

    // Prescaler and digit index; idx names the digit loaded into the
    // output registers on the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads park in pending and move to display only on the
    // frame boundary; a load landing on the boundary bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else if (load && boundary) begin
            disp_val   <= value;
            disp_dp    <= dp_in;
            disp_blank <= blank_in;
            pend_valid <= 1'b0;
        end else begin
            if (boundary && pend_valid) begin
                disp_val   <= pend_val;
                disp_dp    <= pend_dp;
                disp_blank <= pend_blank;
                pend_valid <= 1'b0;
            end
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
                pend_valid <= 1'b1;
            end
        end
    end

`ifdef SSEG_LEAD_ZERO_BLANK_EN
    // Leading-zero suppression from the top digit down to digit 1.
    always_comb begin
        logic leading;
        lzb_mask = '0;
        leading  = 1'b1;
        for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
            if (leading && (disp_val[4*i +: 4] == 4'h0)) begin
                lzb_mask[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Select the nibble, dp and dark flag of the digit about to be shown.
    always_comb begin
        nibble   = '0;
        dig_dp   = 1'b0;
        dig_dark = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                nibble   = disp_val[4*i +: 4];
                dig_dp   = disp_dp[i];
                dig_dark = disp_blank[i] | lzb_mask[i];
            end
        end
    end

    sseg_hex_decode u_decode (
        .nibble (nibble),
        .seg    (seg)
    );

    // Anode, cathode and frame pulse update together on tick to avoid ghosting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sseg_anode   <= '1;
            sseg_cathode <= '1;
            frame_start  <= 1'b0;
        end else if (tick) begin
            sseg_anode   <= ~(N_DIGITS'(1) << idx);
            sseg_cathode <= {~dig_dp, dig_dark ? SEG_OFF : seg};
            frame_start  <= (idx == '0);
        end else begin
            frame_start  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed self-checking bench for sseg_scan_driver (N_DIGITS=4, REFRESH_DIV=4).
module tb_sseg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [7:0]  sseg_cathode;
    logic [3:0]  sseg_anode;
    logic        frame_start;

    int vectors     = 0;
    int miscompares = 0;

    sseg_scan_driver #(.N_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .value        (value),
        .dp_in        (dp_in),
        .blank_in     (blank_in),
        .sseg_cathode (sseg_cathode),
        .sseg_anode   (sseg_anode),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; presents a one-cycle load strobe.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        value    = v;
        dp_in    = dp;
        blank_in = bl;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    // Advance to the negedge just after the next digit-0 slot begins.
    task automatic sync_frame();
        int n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL sync_frame: frame_start=%b after %0d cycles, want 1", frame_start, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sseg_anode !== 4'hF || sseg_cathode !== 8'hFF || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: anode=%h cathode=%h fs=%b, want F FF 0",
                     sseg_anode, sseg_cathode, frame_start);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (sseg_anode !== 4'hF || sseg_cathode !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_dark3: anode=%h cathode=%h, want F FF", sseg_anode, sseg_cathode);
        end
        @(negedge clk);
        vectors++;
        if (sseg_anode !== 4'hE || sseg_cathode !== 8'hC0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first: anode=%h cathode=%h fs=%b, want E C0 1",
                     sseg_anode, sseg_cathode, frame_start);
        end
    endtask

    task automatic test_scan();
        logic [3:0] an_e[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] ca_e[4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        int fs_count = 0;
        do_load(16'h12AF, 4'b0000, 4'b0000);
        sync_frame();
        for (int s = 0; s < 8; s++) begin
            int d = s % 4;
            vectors++;
            if (sseg_anode !== an_e[d] || sseg_cathode !== ca_e[d] || frame_start !== (d == 0)) begin
                miscompares++;
                $display("FAIL scan_slot%0d: anode=%h cathode=%h fs=%b, want %h %h %b",
                         s, sseg_anode, sseg_cathode, frame_start, an_e[d], ca_e[d], (d == 0));
            end
            if (frame_start === 1'b1) fs_count++;
            repeat (3) begin
                @(negedge clk);
                if (frame_start === 1'b1) fs_count++;
            end
            @(negedge clk);
        end
        vectors++;
        if (fs_count != 2) begin
            miscompares++;
            $display("FAIL scan_frame_pulses: %0d pulses in 32 clk, want 2", fs_count);
        end
    endtask

    task automatic test_masks();
        logic [3:0] an_e[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] ca_e[4] = '{8'h8E, 8'h08, 8'hA4, 8'hFF};
        do_load(16'h12AF, 4'b0010, 4'b1000);
        sync_frame();
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (sseg_anode !== an_e[d] || sseg_cathode !== ca_e[d]) begin
                miscompares++;
                $display("FAIL masks_digit%0d: anode=%h cathode=%h, want %h %h",
                         d, sseg_anode, sseg_cathode, an_e[d], ca_e[d]);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_tear_free();
        do_load(16'h3333, 4'b0000, 4'b0000);
        sync_frame();
        vectors++;
        if (sseg_cathode !== 8'hB0) begin
            miscompares++;
            $display("FAIL tear_base: cathode=%h, want B0", sseg_cathode);
        end
        value = 16'h1111; dp_in = '0; blank_in = '0; load = 1'b1;
        @(negedge clk);
        value = 16'h2222;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 1; s < 9; s++) begin
            logic [7:0] exp_c;
            exp_c = (s < 4) ? 8'hB0 : 8'hA4;
            vectors++;
            if (sseg_cathode !== exp_c || sseg_anode !== ~(4'b0001 << (s % 4))) begin
                miscompares++;
                $display("FAIL tear_slot%0d: anode=%h cathode=%h, want cathode %h",
                         s, sseg_anode, sseg_cathode, exp_c);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back_boundary_load();
        logic [7:0] ca_e[4] = '{8'hF8, 8'h82, 8'h92, 8'h99};
        sync_frame();
        repeat (11) @(negedge clk);
        value = 16'h4567; dp_in = '0; blank_in = '0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        vectors++;
        if (sseg_anode !== 4'h7 || sseg_cathode !== 8'hA4) begin
            miscompares++;
            $display("FAIL boundary_old_digit3: anode=%h cathode=%h, want 7 A4",
                     sseg_anode, sseg_cathode);
        end
        repeat (4) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (sseg_cathode !== ca_e[d] || (d == 0 && frame_start !== 1'b1)) begin
                miscompares++;
                $display("FAIL boundary_new_digit%0d: cathode=%h fs=%b, want %h",
                         d, sseg_cathode, frame_start, ca_e[d]);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_midframe();
        sync_frame();
        repeat (8) @(negedge clk);
        vectors++;
        if (sseg_anode !== 4'hB) begin
            miscompares++;
            $display("FAIL midreset_pre: anode=%h, want B", sseg_anode);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (sseg_anode !== 4'hF || sseg_cathode !== 8'hFF || frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_dark: anode=%h cathode=%h fs=%b, want F FF 0",
                     sseg_anode, sseg_cathode, frame_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (sseg_anode !== 4'hF || sseg_cathode !== 8'hFF) begin
            miscompares++;
            $display("FAIL midreset_still_dark: anode=%h cathode=%h, want F FF",
                     sseg_anode, sseg_cathode);
        end
        @(negedge clk);
        vectors++;
        if (sseg_anode !== 4'hE || sseg_cathode !== 8'hC0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_restart: anode=%h cathode=%h fs=%b, want E C0 1",
                     sseg_anode, sseg_cathode, frame_start);
        end
    endtask

    task automatic test_leading_zero();
`ifdef SSEG_LEAD_ZERO_BLANK_EN
        logic [7:0] ca_a[4] = '{8'hC0, 8'h92, 8'hFF, 8'h7F};
        logic [7:0] ca_b[4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`else
        logic [7:0] ca_a[4] = '{8'hC0, 8'h92, 8'hC0, 8'h40};
        logic [7:0] ca_b[4] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        do_load(16'h0050, 4'b1000, 4'b0000);
        sync_frame();
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (sseg_cathode !== ca_a[d] || sseg_anode !== ~(4'b0001 << d)) begin
                miscompares++;
                $display("FAIL lzb_0050_digit%0d: anode=%h cathode=%h, want cathode %h",
                         d, sseg_anode, sseg_cathode, ca_a[d]);
            end
            repeat (4) @(negedge clk);
        end
        do_load(16'h0000, 4'b0000, 4'b0000);
        sync_frame();
        for (int d = 0; d < 4; d++) begin
            vectors++;
            if (sseg_cathode !== ca_b[d]) begin
                miscompares++;
                $display("FAIL lzb_0000_digit%0d: cathode=%h, want %h", d, sseg_cathode, ca_b[d]);
            end
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_masks();
        test_tear_free();
        test_back_to_back_boundary_load();
        test_reset_midframe();
        test_leading_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
